// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes and an iterative shift-add multiplier.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [4:0]       ctrl_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_mcand, r_acc, w_acc_nxt;
  logic [WIDTH-1:0]   r_mplier, r_result, w_a, w_b, w_res;
  logic [WIDTH:0]     w_sum;
  logic               r_zero, r_cout, r_ovf;
  logic               w_accept, w_is_mul, w_legal, w_arith, w_ovf, w_slt, w_last;
  assign w_accept  = in_valid_i & in_ready_o;
  assign w_is_mul  = MUL_EN && ctrl_i == 5'b10010;
  assign w_legal   = ctrl_i inside {5'b00000, 5'b00001, 5'b00010, 5'b00110,
                                    5'b00111, 5'b01100, 5'b01101};
  assign w_a       = ctrl_i[3] ? ~src1_i : src1_i;
  assign w_b       = ctrl_i[2] ? ~src2_i : src2_i;
  assign w_sum     = {1'b0, w_a} + {1'b0, w_b} + (WIDTH+1)'(ctrl_i[2]);
  // Same-sign inputs producing an opposite-sign sum == carry-in(MSB) xor carry-out(MSB).
  assign w_ovf     = (w_a[WIDTH-1] == w_b[WIDTH-1]) & (w_sum[WIDTH-1] != w_a[WIDTH-1]);
  assign w_slt     = w_sum[WIDTH-1] ^ w_ovf;
  assign w_arith   = w_legal & ctrl_i[1];
  assign w_res     = !w_legal               ? '0 :
                     ctrl_i[1:0] == 2'b00   ? w_a & w_b :
                     ctrl_i[1:0] == 2'b01   ? w_a | w_b :
                     ctrl_i[1:0] == 2'b10   ? w_sum[WIDTH-1:0] :
                                              {{(WIDTH-1){1'b0}}, w_slt};
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_last    = r_cnt == CW'(1);
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  always_comb
    w_state_nxt = w_accept                         ? (w_is_mul ? MUL : DONE) :
                  r_state == MUL                   ? (w_last ? DONE : MUL) :
                  (r_state == DONE && out_ready_i) ? IDLE : r_state;
  always_comb begin
    in_ready_o  = r_state == IDLE || (r_state == DONE && out_ready_i);
    out_valid_o = r_state == DONE;
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_accept && w_is_mul) begin
      r_mcand  <= {{WIDTH{1'b0}}, src1_i};
      r_mplier <= src2_i;
      r_acc    <= '0;
      r_cnt    <= CW'(WIDTH);
    end else if (w_accept) begin
      r_result <= w_res;
      r_zero   <= w_res == '0;
      r_cout   <= w_arith & w_sum[WIDTH];
      r_ovf    <= w_legal && ctrl_i[1:0] == 2'b10 && w_ovf;
    end else if (r_state == MUL) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
      if (w_last) begin
        r_result <= w_acc_nxt[WIDTH-1:0];
        r_zero   <= w_acc_nxt[WIDTH-1:0] == '0;
        r_cout   <= 1'b0;
        r_ovf    <= |w_acc_nxt[2*WIDTH-1:WIDTH];
      end
    end
  assign result_o   = r_result;
  assign zero_o     = r_zero;
  assign cout_o     = r_cout;
  assign overflow_o = r_ovf;
endmodule
